// File: rtl/vec_ctrl_pkg.sv
// vec_ctrl_pkg
//   Shared widths, types and helpers for the vector-engine residual-add
//   controller and its operand-pairing sub-block.
//   No ports; imported with `import vec_ctrl_pkg::*;`.
package vec_ctrl_pkg;

  localparam int DATA_W     = 8;                    // per-lane int8
  localparam int LANES      = 16;                   // lanes per SRAM word
  localparam int SRAM_DEPTH = 256;                  // global SRAM words
  localparam int ADDR_W     = $clog2(SRAM_DEPTH);   // SRAM word address width
  localparam int LEN_W      = ADDR_W + 1;           // len may equal full depth
  localparam int SCALE_W    = 8;                    // unsigned dequant scale
  localparam int SHIFT_W    = 4;                    // requant shift
  localparam int VEC_W      = LANES * DATA_W;       // one SRAM word

  typedef enum logic [2:0] {
    RA_IDLE  = 3'd0,
    RA_CFG   = 3'd1,
    RA_RUN   = 3'd2,
    RA_DRAIN = 3'd3,
    RA_DONE  = 3'd4
  } ra_state_e;

  typedef logic [VEC_W-1:0]  lane_vec_t;
  typedef logic [ADDR_W-1:0] sram_addr_t;

  // Word-address add; the carry out is dropped so addresses wrap modulo the depth.
  function automatic sram_addr_t addr_wrap_add(input sram_addr_t base, input sram_addr_t offset);
    return base + offset;
  endfunction

endpackage

// File: rtl/ra_operand_pair.sv
// ra_operand_pair
//   Pairs read returns into adder operands. Returns arrive A, B, A, B...;
//   the A word is held, and on the B return the pair is presented to the
//   adder in the same cycle together with its word index and finish flag.
// Ports:
//   clk, rst        clock, async active-high reset
//   clr             restart pairing at the beginning of a pass
//   en              accept returns (controller is in RUN or DRAIN)
//   rd_rvld/rd_rdata read return strobe and data
//   len             number of words in this pass
//   in_vld/in_a/in_b/in_idx/in_finish   operand pair towards the adder
module ra_operand_pair
  import vec_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              rd_rvld,
  input  logic [VEC_W-1:0]  rd_rdata,
  input  logic [LEN_W-1:0]  len,
  output logic              in_vld,
  output logic [VEC_W-1:0]  in_a,
  output logic [VEC_W-1:0]  in_b,
  output logic [ADDR_W-1:0] in_idx,
  output logic              in_finish
);

  localparam logic [LEN_W-1:0] IDX_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  logic             phase_b_r;   // next return is a B word
  lane_vec_t        a_hold_r;
  logic [LEN_W-1:0] ret_idx_r;

  logic             ret_vld_s;
  logic             pair_vld_s;
  logic [LEN_W-1:0] last_idx_s;

  assign ret_vld_s  = en & rd_rvld;
  assign pair_vld_s = ret_vld_s & phase_b_r;
  assign last_idx_s = len - IDX_ONE;

  // Return toggle, A holding register and return index counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_b_r <= 1'b0;
      a_hold_r  <= {VEC_W{1'b0}};
      ret_idx_r <= {LEN_W{1'b0}};
    end else if (clr) begin
      phase_b_r <= 1'b0;
      a_hold_r  <= {VEC_W{1'b0}};
      ret_idx_r <= {LEN_W{1'b0}};
    end else if (ret_vld_s) begin
      phase_b_r <= ~phase_b_r;
      if (phase_b_r) begin
        ret_idx_r <= ret_idx_r + IDX_ONE;
      end else begin
        a_hold_r <= rd_rdata;
      end
    end
  end

  // Operand pair goes out combinationally with the B return; zero otherwise.
  always_comb begin
    in_vld    = pair_vld_s;
    in_a      = {VEC_W{1'b0}};
    in_b      = {VEC_W{1'b0}};
    in_idx    = {ADDR_W{1'b0}};
    in_finish = 1'b0;
    if (pair_vld_s) begin
      in_a      = a_hold_r;
      in_b      = rd_rdata;
      in_idx    = ret_idx_r[ADDR_W-1:0];
      in_finish = (ret_idx_r == last_idx_s);
    end else begin
      in_finish = 1'b0;
    end
  end

endmodule

// File: rtl/residual_add_ctrl.sv
// residual_add_ctrl
//   Sequences one residual-add pass X[i] = sat8(round((A[i]*sa + B[i]*sb) >>> sh)).
//   Reads A and B words from the global SRAM through a req/gnt port, feeds the
//   residual_adder lane array and passes its results straight to the SRAM
//   write port.
// Ports:
//   clk, rst                      clock, async active-high reset
//   start, cfg_*                  pass launch and its configuration (latched on start)
//   busy, done                    pass status
//   rd_req/rd_addr/rd_gnt         SRAM read request port (addr held until gnt)
//   rd_rvld/rd_rdata              SRAM read return, in grant order
//   ra_scale_*/ra_shift_*         adder configuration, pulsed once per pass
//   ra_in_*                       operand pair to the adder
//   ra_out_*                      adder result
//   wr_en/wr_addr/wr_data         SRAM write port
module residual_add_ctrl
  import vec_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  cfg_src_a,
  input  logic [ADDR_W-1:0]  cfg_src_b,
  input  logic [ADDR_W-1:0]  cfg_dst,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [SCALE_W-1:0] cfg_scale_a,
  input  logic [SCALE_W-1:0] cfg_scale_b,
  input  logic [SHIFT_W-1:0] cfg_shift,
  output logic               busy,
  output logic               done,
  output logic               rd_req,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic               rd_gnt,
  input  logic               rd_rvld,
  input  logic [VEC_W-1:0]   rd_rdata,
  output logic               ra_scale_vld,
  output logic [SCALE_W-1:0] ra_scale_a,
  output logic [SCALE_W-1:0] ra_scale_b,
  output logic               ra_shift_vld,
  output logic [SHIFT_W-1:0] ra_shift,
  output logic               ra_in_vld,
  output logic [VEC_W-1:0]   ra_in_a,
  output logic [VEC_W-1:0]   ra_in_b,
  output logic [ADDR_W-1:0]  ra_in_addr,
  output logic               ra_in_finish,
  input  logic               ra_out_vld,
  input  logic [VEC_W-1:0]   ra_out_data,
  input  logic [ADDR_W-1:0]  ra_out_addr,
  input  logic               ra_out_finish,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [VEC_W-1:0]   wr_data
);

  localparam logic [LEN_W:0] ISSUE_ONE = {{LEN_W{1'b0}}, 1'b1};

  ra_state_e          state_r, state_s;
  sram_addr_t         src_a_r, src_b_r, dst_r;
  logic [LEN_W-1:0]   len_r;
  logic [SCALE_W-1:0] scale_a_r, scale_b_r;
  logic [SHIFT_W-1:0] shift_r;
  logic [LEN_W:0]     issue_cnt_r;   // grants taken; bit 0 selects B, upper bits are the word index

  logic               accept_s;
  logic               gnt_take_s;
  logic               last_issue_s;
  logic [LEN_W:0]     issue_total_s;
  sram_addr_t         word_idx_s;
  logic               pair_en_s;
  logic               pair_clr_s;

  assign accept_s      = (state_r == RA_IDLE) & start;
  assign gnt_take_s    = (state_r == RA_RUN) & rd_gnt;
  assign issue_total_s = {len_r, 1'b0};
  assign last_issue_s  = ((issue_cnt_r + ISSUE_ONE) == issue_total_s);
  assign word_idx_s    = issue_cnt_r[ADDR_W:1];
  assign pair_en_s     = (state_r == RA_RUN) | (state_r == RA_DRAIN);
  assign pair_clr_s    = (state_r == RA_CFG);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RA_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Configuration latch, loaded only when a start is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_a_r   <= {ADDR_W{1'b0}};
      src_b_r   <= {ADDR_W{1'b0}};
      dst_r     <= {ADDR_W{1'b0}};
      len_r     <= {LEN_W{1'b0}};
      scale_a_r <= {SCALE_W{1'b0}};
      scale_b_r <= {SCALE_W{1'b0}};
      shift_r   <= {SHIFT_W{1'b0}};
    end else if (accept_s) begin
      src_a_r   <= cfg_src_a;
      src_b_r   <= cfg_src_b;
      dst_r     <= cfg_dst;
      len_r     <= cfg_len;
      scale_a_r <= cfg_scale_a;
      scale_b_r <= cfg_scale_b;
      shift_r   <= cfg_shift;
    end
  end

  // Issue counter: advances only on an accepted grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_r <= {(LEN_W+1){1'b0}};
    end else if (accept_s) begin
      issue_cnt_r <= {(LEN_W+1){1'b0}};
    end else if (gnt_take_s) begin
      issue_cnt_r <= issue_cnt_r + ISSUE_ONE;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      RA_IDLE:  if (start) state_s = RA_CFG; else state_s = RA_IDLE;
      RA_CFG:   if (len_r == {LEN_W{1'b0}}) state_s = RA_DONE; else state_s = RA_RUN;
      RA_RUN:   if (gnt_take_s && last_issue_s) state_s = RA_DRAIN; else state_s = RA_RUN;
      RA_DRAIN: if (ra_out_finish) state_s = RA_DONE; else state_s = RA_DRAIN;
      RA_DONE:  state_s = RA_IDLE;
      default:  state_s = RA_IDLE;
    endcase
  end

  // State-decoded outputs: status, read request and adder config strobes.
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    rd_req       = 1'b0;
    rd_addr      = {ADDR_W{1'b0}};
    ra_scale_vld = 1'b0;
    ra_shift_vld = 1'b0;
    case (state_r)
      RA_IDLE: begin
        busy = 1'b0;
      end
      RA_CFG: begin
        busy         = 1'b1;
        ra_scale_vld = 1'b1;
        ra_shift_vld = 1'b1;
      end
      RA_RUN: begin
        busy   = 1'b1;
        rd_req = 1'b1;
        if (issue_cnt_r[0]) begin
          rd_addr = addr_wrap_add(src_b_r, word_idx_s);
        end else begin
          rd_addr = addr_wrap_add(src_a_r, word_idx_s);
        end
      end
      RA_DRAIN: begin
        busy = 1'b1;
      end
      RA_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign ra_scale_a = scale_a_r;
  assign ra_scale_b = scale_b_r;
  assign ra_shift   = shift_r;

  ra_operand_pair u_pair (
    .clk       (clk),
    .rst       (rst),
    .clr       (pair_clr_s),
    .en        (pair_en_s),
    .rd_rvld   (rd_rvld),
    .rd_rdata  (rd_rdata),
    .len       (len_r),
    .in_vld    (ra_in_vld),
    .in_a      (ra_in_a),
    .in_b      (ra_in_b),
    .in_idx    (ra_in_addr),
    .in_finish (ra_in_finish)
  );

  // Writeback passthrough; address and data are zeroed when no write is in flight.
  assign wr_en   = ra_out_vld;
  assign wr_addr = ra_out_vld ? addr_wrap_add(dst_r, ra_out_addr) : {ADDR_W{1'b0}};
  assign wr_data = ra_out_vld ? ra_out_data : {VEC_W{1'b0}};

endmodule

// File: tb/tb_residual_add_ctrl.sv
// tb_residual_add_ctrl
//   Directed bench for residual_add_ctrl. Models the SRAM (req/gnt read port
//   with fixed return latency, write port) and a behavioural residual_adder
//   with fixed latency. Expected values are hand-computed constants.
module tb_residual_add_ctrl;
  import vec_ctrl_pkg::*;

  localparam int RD_LAT  = 2;
  localparam int ADD_LAT = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [ADDR_W-1:0]  cfg_src_a, cfg_src_b, cfg_dst;
  logic [LEN_W-1:0]   cfg_len;
  logic [SCALE_W-1:0] cfg_scale_a, cfg_scale_b;
  logic [SHIFT_W-1:0] cfg_shift;
  logic               busy, done, rd_req, rd_gnt, rd_rvld;
  logic [ADDR_W-1:0]  rd_addr;
  logic [VEC_W-1:0]   rd_rdata;
  logic               ra_scale_vld, ra_shift_vld, ra_in_vld, ra_in_finish;
  logic [SCALE_W-1:0] ra_scale_a, ra_scale_b;
  logic [SHIFT_W-1:0] ra_shift;
  logic [VEC_W-1:0]   ra_in_a, ra_in_b, ra_out_data, wr_data;
  logic [ADDR_W-1:0]  ra_in_addr, ra_out_addr, wr_addr;
  logic               ra_out_vld, ra_out_finish, wr_en;

  residual_add_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_src_a(cfg_src_a), .cfg_src_b(cfg_src_b), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .cfg_scale_a(cfg_scale_a), .cfg_scale_b(cfg_scale_b), .cfg_shift(cfg_shift),
    .busy(busy), .done(done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_rvld(rd_rvld), .rd_rdata(rd_rdata),
    .ra_scale_vld(ra_scale_vld), .ra_scale_a(ra_scale_a), .ra_scale_b(ra_scale_b),
    .ra_shift_vld(ra_shift_vld), .ra_shift(ra_shift),
    .ra_in_vld(ra_in_vld), .ra_in_a(ra_in_a), .ra_in_b(ra_in_b),
    .ra_in_addr(ra_in_addr), .ra_in_finish(ra_in_finish),
    .ra_out_vld(ra_out_vld), .ra_out_data(ra_out_data),
    .ra_out_addr(ra_out_addr), .ra_out_finish(ra_out_finish),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [VEC_W-1:0] data; } rd_ent_t;
  typedef struct { int due; logic [VEC_W-1:0] data; logic [ADDR_W-1:0] addr; logic fin; } add_ent_t;

  logic [VEC_W-1:0]  mem [SRAM_DEPTH];
  rd_ent_t           rd_q[$];
  add_ent_t          add_q[$];
  logic [ADDR_W-1:0] grant_q[$];
  logic [ADDR_W-1:0] wr_q[$];

  int cyc = 0;
  int start_cyc, done_cyc;
  int grant_cnt, in_cnt, fin_cnt, done_cnt, scale_cnt, rdreq_cnt, wr_cnt;
  int stall_cnt, stall_seen, stall_bad;
  int fin_idx;
  bit stall_mode = 1'b0;
  logic [SCALE_W-1:0] m_sa, m_sb;
  logic [SHIFT_W-1:0] m_sh;

  int n_checks = 0;
  int n_err    = 0;

  // Single comparison point: counts every check, reports mismatches.
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] rep8(input logic [7:0] b);
    return {LANES{b}};
  endfunction

  // Behavioural adder lane: sat8(round((a*sa + b*sb) >>> sh)).
  function automatic logic [7:0] lane_res(input logic [7:0] a, input logic [7:0] b,
                                          input logic [SCALE_W-1:0] sa, input logic [SCALE_W-1:0] sb,
                                          input logic [SHIFT_W-1:0] sh);
    int av, bv, s;
    av = int'($signed(a));
    bv = int'($signed(b));
    s  = av * int'(sa) + bv * int'(sb);
    if (sh != '0) s = s + (1 <<< (int'(sh) - 1));
    s = s >>> int'(sh);
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    return s[7:0];
  endfunction

  function automatic logic [VEC_W-1:0] vec_res(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
    logic [VEC_W-1:0] r;
    for (int l = 0; l < LANES; l++)
      r[l*8 +: 8] = lane_res(a[l*8 +: 8], b[l*8 +: 8], m_sa, m_sb, m_sh);
    return r;
  endfunction

  // SRAM + arbiter + adder model: drive at the falling edge, sample 1 time unit later.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      rd_q.delete();
      add_q.delete();
      rd_gnt = 1'b0; rd_rvld = 1'b0; rd_rdata = '0;
      ra_out_vld = 1'b0; ra_out_data = '0; ra_out_addr = '0; ra_out_finish = 1'b0;
    end else begin
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        rd_rvld = 1'b1; rd_rdata = rd_q[0].data; void'(rd_q.pop_front());
      end else begin
        rd_rvld = 1'b0; rd_rdata = '0;
      end
      if (add_q.size() > 0 && add_q[0].due == cyc) begin
        ra_out_vld = 1'b1; ra_out_data = add_q[0].data;
        ra_out_addr = add_q[0].addr; ra_out_finish = add_q[0].fin;
        void'(add_q.pop_front());
      end else begin
        ra_out_vld = 1'b0; ra_out_data = '0; ra_out_addr = '0; ra_out_finish = 1'b0;
      end
      if (stall_mode && grant_cnt == 2 && stall_cnt < 5 && rd_req) begin
        rd_gnt = 1'b0; stall_cnt++;
      end else begin
        rd_gnt = rd_req;
      end
    end
    #1;
    if (!rst) begin
      if (rd_req) rdreq_cnt++;
      if (rd_req && !rd_gnt) begin
        stall_seen++;
        if (rd_addr !== 8'h11) stall_bad++;
      end
      if (rd_req && rd_gnt) begin
        grant_q.push_back(rd_addr);
        rd_q.push_back('{cyc + RD_LAT, mem[rd_addr]});
        grant_cnt++;
      end
      if (ra_scale_vld) begin scale_cnt++; m_sa = ra_scale_a; m_sb = ra_scale_b; end
      if (ra_shift_vld) m_sh = ra_shift;
      if (ra_in_vld) begin
        in_cnt++;
        add_q.push_back('{cyc + ADD_LAT, vec_res(ra_in_a, ra_in_b), ra_in_addr, ra_in_finish});
        if (ra_in_finish) begin fin_cnt++; fin_idx = int'(ra_in_addr); end
      end
      if (wr_en) begin mem[wr_addr] = wr_data; wr_q.push_back(wr_addr); wr_cnt++; end
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  task automatic clear_stats();
    @(negedge clk); #2;
    grant_q.delete(); wr_q.delete();
    grant_cnt = 0; in_cnt = 0; fin_cnt = 0; done_cnt = 0; scale_cnt = 0;
    rdreq_cnt = 0; wr_cnt = 0; stall_cnt = 0; stall_seen = 0; stall_bad = 0; fin_idx = -1;
  endtask

  task automatic set_cfg(input logic [7:0] sa_addr, input logic [7:0] sb_addr, input logic [7:0] d,
                         input int len, input logic [7:0] sa, input logic [7:0] sb, input logic [3:0] sh);
    cfg_src_a = sa_addr; cfg_src_b = sb_addr; cfg_dst = d; cfg_len = LEN_W'(len);
    cfg_scale_a = sa; cfg_scale_b = sb; cfg_shift = sh;
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (done_cnt == 0 && c < 300) begin @(negedge clk); #2; c++; end
    chk({tag, " done"}, done_cnt, 1);
    repeat (2) @(negedge clk);
    #2;
    chk({tag, " idle"}, busy, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1; #2 start_cyc = cyc;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_grants(input int n);
    int c = 0;
    while (grant_cnt < n && c < 100) begin @(negedge clk); #2; c++; end
    chk("grant wait", grant_cnt >= n, 1);
  endtask

  // A[i] = i+1, B[i] = 10*(i+1), sa=2, sb=1, sh=0 -> X[i] = 12*(i+1).
  task automatic load_base();
    for (int i = 0; i < 4; i++) begin
      mem[8'h10 + i] = rep8(8'(i + 1));
      mem[8'h20 + i] = rep8(8'(10 * (i + 1)));
      mem[8'h30 + i] = '0;
    end
    set_cfg(8'h10, 8'h20, 8'h30, 4, 8'd2, 8'd1, 4'd0);
  endtask

  task automatic check_base(input string tag);
    logic [7:0] exp_res [4];
    logic [7:0] ea;
    exp_res = '{8'h0C, 8'h18, 8'h24, 8'h30};
    chk({tag, " grants"}, grant_q.size(), 8);
    for (int k = 0; k < 8; k++) begin
      ea = (k % 2 == 0) ? 8'(8'h10 + k / 2) : 8'(8'h20 + k / 2);
      chk({tag, " rd_addr"}, (k < grant_q.size()) ? grant_q[k] : 8'hXX, ea);
    end
    chk({tag, " in_vld count"}, in_cnt, 4);
    chk({tag, " finish count"}, fin_cnt, 1);
    chk({tag, " finish idx"}, fin_idx, 3);
    chk({tag, " cfg pulses"}, scale_cnt, 1);
    for (int i = 0; i < 4; i++) chk({tag, " result"}, mem[8'h30 + i], rep8(exp_res[i]));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    set_cfg(8'h00, 8'h00, 8'h00, 0, 8'd0, 8'd0, 4'd0);
    for (int i = 0; i < SRAM_DEPTH; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst rd_req", rd_req, 0);
    chk("rst rd_addr", rd_addr, 0);
    chk("rst scale_vld", ra_scale_vld, 0);
    chk("rst in_vld", ra_in_vld, 0);
    chk("rst wr_en", wr_en, 0);
    @(negedge clk); rst = 1'b0;

    // Basic pass, grant always available.
    load_base(); clear_stats();
    pulse_start(); wait_done("t1");
    check_base("t1");

    // Same pass with a 5-cycle grant stall on the third request.
    load_base(); clear_stats(); stall_mode = 1'b1;
    pulse_start(); wait_done("t2");
    stall_mode = 1'b0;
    chk("t2 stall cycles", stall_seen, 5);
    chk("t2 stall addr moved", stall_bad, 0);
    check_base("t2");

    // Zero-length pass.
    clear_stats(); set_cfg(8'h10, 8'h20, 8'h30, 0, 8'd1, 8'd1, 4'd0);
    pulse_start(); wait_done("t3");
    chk("t3 rd_req seen", rdreq_cnt, 0);
    chk("t3 writes", wr_cnt, 0);
    chk("t3 cfg pulses", scale_cnt, 1);
    chk("t3 done latency", done_cyc - start_cyc, 2);

    // Saturation / rounding path.
    mem[8'h40] = rep8(8'h7F); mem[8'h50] = rep8(8'h7F);
    mem[8'h41] = rep8(8'h80); mem[8'h51] = rep8(8'h80);
    clear_stats(); set_cfg(8'h40, 8'h50, 8'h60, 2, 8'd1, 8'd1, 4'd1);
    pulse_start(); wait_done("t4");
    chk("t4 lane 7F", mem[8'h60], rep8(8'h7F));
    chk("t4 lane 80", mem[8'h61], rep8(8'h80));
    chk("t4 finish idx", fin_idx, 1);

    // Destination wraps past the top of the SRAM.
    clear_stats(); set_cfg(8'h70, 8'h78, 8'(SRAM_DEPTH - 2), 4, 8'd1, 8'd1, 4'd0);
    pulse_start(); wait_done("t5");
    chk("t5 writes", wr_q.size(), 4);
    chk("t5 wr_addr0", (wr_q.size() > 0) ? wr_q[0] : 8'hXX, 8'hFE);
    chk("t5 wr_addr1", (wr_q.size() > 1) ? wr_q[1] : 8'hXX, 8'hFF);
    chk("t5 wr_addr2", (wr_q.size() > 2) ? wr_q[2] : 8'hXX, 8'h00);
    chk("t5 wr_addr3", (wr_q.size() > 3) ? wr_q[3] : 8'hXX, 8'h01);

    // Start while busy is ignored (new cfg must not be picked up).
    load_base(); clear_stats();
    pulse_start(); wait_grants(2);
    @(negedge clk); set_cfg(8'h00, 8'h00, 8'h00, 1, 8'd1, 8'd1, 4'd0); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("t6");
    check_base("t6");
    chk("t6 single done", done_cnt, 1);

    // Reset in the middle of RUN.
    load_base(); clear_stats();
    pulse_start(); wait_grants(3);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #2;
    chk("t7 busy", busy, 0);
    chk("t7 rd_req", rd_req, 0);
    chk("t7 in_vld", ra_in_vld, 0);
    chk("t7 wr_en", wr_en, 0);
    chk("t7 done", done, 0);
    @(negedge clk); rst = 1'b0;
    repeat (12) @(negedge clk);
    #2;
    chk("t7 no done after reset", done_cnt, 0);
    chk("t7 stays idle", busy, 0);

    // A fresh pass after reset completes normally.
    load_base(); clear_stats();
    pulse_start(); wait_done("t8");
    check_base("t8");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
